// File: rtl/triplet_pkg.sv
// triplet_pkg: shared constants for the triplet collector.
// Holds the collector state encoding and the default word width,
// gap limit and delivered-triplet counter width.
package triplet_pkg;

    localparam int WIDTH_DEF   = 3;
    localparam int GAP_MAX_DEF = 15;
    localparam int CNT_W_DEF   = 8;

    // Collector states: expecting A, B or C, or holding a full triplet
    typedef logic [1:0] state_t;

    localparam state_t S0   = 2'd0;
    localparam state_t S1   = 2'd1;
    localparam state_t S2   = 2'd2;
    localparam state_t FULL = 2'd3;

endpackage

// File: rtl/triplet_collector_gap_timer.sv
// gap_timer: counts idle cycles while enabled and flags expiry on the
// cycle the count would reach GAP_MAX. GAP_MAX = 0 never expires.
module gap_timer
    import triplet_pkg::*;
#(
    parameter int GAP_MAX = GAP_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (GAP_MAX < 2) ? 1 : $clog2(GAP_MAX + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    generate
        if (GAP_MAX == 0) begin : g_never
            assign expire = 1'b0;
        end else begin : g_limit
            assign expire = enable && (count_q == CW'(GAP_MAX - 1));
        end
    endgenerate

    // Next count: restart on clear or expiry, otherwise step while enabled
    always_comb begin
        count_d = count_q;
        if (clear || expire) begin
            count_d = '0;
        end else if (enable && (GAP_MAX != 0)) begin
            count_d = count_q + CW'(1);
        end
    end

    // Idle-cycle counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/triplet_collector.sv
// triplet_collector: gathers three consecutive stream words into a
// parallel A/B/C triplet with its own valid/ready handshake, discards
// stalled partial triplets and counts delivered triplets.
// Optional macro TRIPLET_MATCH_FLAG_EN adds out_match (A == B == C).
module triplet_collector
    import triplet_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int GAP_MAX = GAP_MAX_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic             drop_pulse,
    output logic [CNT_W-1:0] triplet_cnt
`ifdef TRIPLET_MATCH_FLAG_EN
    ,
    output logic             out_match
`endif
);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  c_q, c_d;
    logic              drop_q, drop_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_fire;
    logic              out_fire;
    logic              gap_enable;
    logic              gap_expire;
`ifdef TRIPLET_MATCH_FLAG_EN
    logic              match_q, match_d;
`endif

    // Handshake: FULL passes out_ready through so a word can enter in the
    // same cycle the held triplet leaves; flush blocks all input.
    always_comb begin
        out_valid = (state_q == FULL);
        if (flush) begin
            in_ready = 1'b0;
        end else if (state_q == FULL) begin
            in_ready = out_ready;
        end else begin
            in_ready = 1'b1;
        end
        in_fire    = in_valid && in_ready;
        out_fire   = out_valid && out_ready;
        gap_enable = ((state_q == S1) || (state_q == S2)) && !in_fire && !flush;
    end

    // The timer only runs while a partial triplet waits for its next word
    gap_timer #(
        .GAP_MAX (GAP_MAX)
    ) u_gap_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!gap_enable),
        .enable (gap_enable),
        .expire (gap_expire)
    );

    // Collection FSM: capture A/B/C, hold the triplet, discard on timeout
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        drop_d  = 1'b0;
        cnt_d   = cnt_q;
`ifdef TRIPLET_MATCH_FLAG_EN
        match_d = match_q;
`endif
        if (flush) begin
            state_d = S0;
        end else begin
            case (state_q)
                S0: begin
                    if (in_fire) begin
                        a_d     = in_data;
                        state_d = S1;
                    end
                end
                S1: begin
                    if (in_fire) begin
                        b_d     = in_data;
                        state_d = S2;
                    end else if (gap_expire) begin
                        drop_d  = 1'b1;
                        state_d = S0;
                    end
                end
                S2: begin
                    if (in_fire) begin
                        c_d     = in_data;
`ifdef TRIPLET_MATCH_FLAG_EN
                        match_d = (in_data == a_q) && (in_data == b_q);
`endif
                        state_d = FULL;
                    end else if (gap_expire) begin
                        drop_d  = 1'b1;
                        state_d = S0;
                    end
                end
                default: begin
                    if (out_fire) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (in_fire) begin
                            a_d     = in_data;
                            state_d = S1;
                        end else begin
                            state_d = S0;
                        end
                    end
                end
            endcase
        end
    end

    // State, triplet words, drop pulse and delivery counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef TRIPLET_MATCH_FLAG_EN
            match_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
`ifdef TRIPLET_MATCH_FLAG_EN
            match_q <= match_d;
`endif
        end
    end

    assign out_a       = a_q;
    assign out_b       = b_q;
    assign out_c       = c_q;
    assign drop_pulse  = drop_q;
    assign triplet_cnt = cnt_q;
`ifdef TRIPLET_MATCH_FLAG_EN
    assign out_match   = match_q;
`endif

endmodule

// File: tb/tb_triplet_collector.sv
// tb_triplet_collector: directed table-driven bench for triplet_collector
// built with WIDTH = 3, GAP_MAX = 4 and CNT_W = 2.
module tb_triplet_collector;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_a;
    logic [2:0] out_b;
    logic [2:0] out_c;
    logic       drop_pulse;
    logic [1:0] triplet_cnt;
`ifdef TRIPLET_MATCH_FLAG_EN
    logic       out_match;
`endif

    int tests_run;
    int tests_failed;

    typedef struct {
        logic       in_valid;
        logic [2:0] in_data;
        logic       out_ready;
        logic       e_valid;
        logic [2:0] e_a;
        logic [2:0] e_b;
        logic [2:0] e_c;
        logic       e_in_ready;
        logic       e_drop;
        logic [1:0] e_cnt;
        logic       e_match;
    } vec_t;

    vec_t vecs [9];

    triplet_collector #(
        .WIDTH   (3),
        .GAP_MAX (4),
        .CNT_W   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_c       (out_c),
        .drop_pulse  (drop_pulse),
        .triplet_cnt (triplet_cnt)
`ifdef TRIPLET_MATCH_FLAG_EN
        ,
        .out_match   (out_match)
`endif
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    // Directed sequence: table first, then multi-cycle corner cases
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 3'd0;
        out_ready = 1'b0;

        #12;
        checkOutput("reset_valid", out_valid, 0);
        checkOutput("reset_a", out_a, 0);
        checkOutput("reset_drop", drop_pulse, 0);
        checkOutput("reset_cnt", triplet_cnt, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        rst = 1'b0;

        // in_valid data out_ready | valid a b c in_ready drop cnt match
        vecs[0] = '{1'b1, 3'd5, 1'b1, 1'b0, 3'd5, 3'd0, 3'd0, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[1] = '{1'b1, 3'd5, 1'b1, 1'b0, 3'd5, 3'd5, 3'd0, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[2] = '{1'b1, 3'd5, 1'b1, 1'b1, 3'd5, 3'd5, 3'd5, 1'b1, 1'b0, 2'd0, 1'b1};
        vecs[3] = '{1'b0, 3'd0, 1'b1, 1'b0, 3'd5, 3'd5, 3'd5, 1'b1, 1'b0, 2'd1, 1'b1};
        vecs[4] = '{1'b1, 3'd5, 1'b1, 1'b0, 3'd5, 3'd5, 3'd5, 1'b1, 1'b0, 2'd1, 1'b1};
        vecs[5] = '{1'b1, 3'd5, 1'b1, 1'b0, 3'd5, 3'd5, 3'd5, 1'b1, 1'b0, 2'd1, 1'b1};
        vecs[6] = '{1'b1, 3'd4, 1'b0, 1'b1, 3'd5, 3'd5, 3'd4, 1'b0, 1'b0, 2'd1, 1'b0};
        vecs[7] = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 3'd5, 3'd4, 1'b0, 1'b0, 2'd1, 1'b0};
        vecs[8] = '{1'b0, 3'd0, 1'b1, 1'b0, 3'd5, 3'd5, 3'd4, 1'b1, 1'b0, 2'd2, 1'b0};

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready, 1'b0);
            checkOutput($sformatf("vec%0d_valid", i), out_valid, vecs[i].e_valid);
            checkOutput($sformatf("vec%0d_a", i), out_a, vecs[i].e_a);
            checkOutput($sformatf("vec%0d_b", i), out_b, vecs[i].e_b);
            checkOutput($sformatf("vec%0d_c", i), out_c, vecs[i].e_c);
            checkOutput($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_in_ready);
            checkOutput($sformatf("vec%0d_drop", i), drop_pulse, vecs[i].e_drop);
            checkOutput($sformatf("vec%0d_cnt", i), triplet_cnt, vecs[i].e_cnt);
`ifdef TRIPLET_MATCH_FLAG_EN
            if (vecs[i].e_valid) begin
                checkOutput($sformatf("vec%0d_match", i), out_match, vecs[i].e_match);
            end
`endif
        end

        // Backpressure: triplet 1,2,3 held for 10 cycles while a word waits
        applyStimulus(1'b1, 3'd1, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd3, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_valid", out_valid, 1);
            checkOutput("bp_a", out_a, 1);
            checkOutput("bp_b", out_b, 2);
            checkOutput("bp_c", out_c, 3);
            checkOutput("bp_in_ready", in_ready, 0);
            applyStimulus(1'b1, 3'd7, 1'b0, 1'b0);
        end
`ifdef TRIPLET_MATCH_FLAG_EN
        checkOutput("bp_match", out_match, 0);
`endif
        applyStimulus(1'b1, 3'd6, 1'b1, 1'b0);
        checkOutput("pass_valid", out_valid, 0);
        checkOutput("pass_a", out_a, 6);
        checkOutput("pass_cnt", triplet_cnt, 3);

        // Timeout: one word captured, then idle until the partial is dropped
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
            checkOutput($sformatf("timeout_drop%0d", i), drop_pulse, (i == 4) ? 1 : 0);
            checkOutput($sformatf("timeout_valid%0d", i), out_valid, 0);
        end
        applyStimulus(1'b1, 3'd7, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd7, 1'b0, 1'b0);
        checkOutput("fresh_valid", out_valid, 1);
        checkOutput("fresh_a", out_a, 7);
        checkOutput("fresh_b", out_b, 0);
        checkOutput("fresh_c", out_c, 7);
`ifdef TRIPLET_MATCH_FLAG_EN
        checkOutput("fresh_match", out_match, 0);
`endif
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
        checkOutput("wrap_cnt", triplet_cnt, 0);

        // Gap boundary: word arrives on the cycle the count would expire
        applyStimulus(1'b1, 3'd2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
            checkOutput("gap_idle_drop", drop_pulse, 0);
        end
        applyStimulus(1'b1, 3'd3, 1'b1, 1'b0);
        checkOutput("gap_edge_drop", drop_pulse, 0);
        checkOutput("gap_edge_b", out_b, 3);
        applyStimulus(1'b1, 3'd4, 1'b1, 1'b0);
        checkOutput("gap_full_valid", out_valid, 1);
        checkOutput("gap_full_a", out_a, 2);
        checkOutput("gap_full_c", out_c, 4);
        checkOutput("gap_full_drop", drop_pulse, 0);
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
        checkOutput("wrap_cnt_again", triplet_cnt, 1);

        // Flush in S2: word presented during flush is ignored, no drop
        applyStimulus(1'b1, 3'd1, 1'b1, 1'b0);
        applyStimulus(1'b1, 3'd2, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_data  = 3'd5;
        flush    = 1'b1;
        #1;
        checkOutput("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        checkOutput("flush_valid", out_valid, 0);
        checkOutput("flush_drop", drop_pulse, 0);
        checkOutput("flush_a_kept", out_a, 1);
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
        checkOutput("post_flush_drop", drop_pulse, 0);
        checkOutput("post_flush_valid", out_valid, 0);
        applyStimulus(1'b1, 3'd6, 1'b1, 1'b0);
        checkOutput("post_flush_a", out_a, 6);

        // Flush while FULL with out_ready high: triplet not counted
        applyStimulus(1'b1, 3'd1, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd2, 1'b0, 1'b0);
        checkOutput("hold_valid", out_valid, 1);
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b1);
        checkOutput("flush_full_valid", out_valid, 0);
        checkOutput("flush_full_cnt", triplet_cnt, 1);

        // Async reset while FULL clears outputs before the next edge
        applyStimulus(1'b1, 3'd3, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd4, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd5, 1'b0, 1'b0);
        checkOutput("pre_rst_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_a", out_a, 0);
        checkOutput("rst_b", out_b, 0);
        checkOutput("rst_c", out_c, 0);
        checkOutput("rst_cnt", triplet_cnt, 0);
        checkOutput("rst_drop", drop_pulse, 0);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
        checkOutput("post_rst_valid", out_valid, 0);
        checkOutput("post_rst_in_ready", in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
